mem_port_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one memory port among four requesters:
//    0 = instruction fetch, 1 = load/store, 2 = debug, 3 = DMA.
//  o_sel drives the 2-bit select of the 4:1 address/wdata muxes in front of the memory.

---
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared-memory-port bundle: four requester lanes, the response path back to them,
// and the single memory request/response channel.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [3:0]      i_req;
  logic [3:0]      i_we;
  logic [4*AW-1:0] i_addr;
  logic [4*DW-1:0] i_wdata;
  logic [3:0]      o_ack;
  logic            o_err;
  logic [DW-1:0]   o_rdata;
  logic [1:0]      o_sel;
  logic            o_mem_valid;
  logic            o_mem_we;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_mem_wdata;
  logic            i_mem_ready;
  logic [DW-1:0]   i_mem_rdata;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_mem_ready, i_mem_rdata,
    output o_ack, o_err, o_rdata, o_sel, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_mem_ready, i_mem_rdata,
    input  o_ack, o_err, o_rdata, o_sel, o_mem_valid, o_mem_we, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among fetch, load/store, debug and DMA,
// with a watchdog that terminates accesses the memory never completes.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no access in flight; grant the next requester round-robin
// ST_BUSY | memory request held; wait for ready or watchdog expiry
// ST_RESP | one-cycle ack to the granted requester, err/rdata valid
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input logic              i_clk,
  input logic              i_rst_n,
  mem_port_arbiter_if.slave bus
);

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t        state_q, state_d;
  logic [1:0]    rr_ptr_q;
  logic [1:0]    sel_q;
  logic [1:0]    winner;
  logic [CW-1:0] cnt_q;
  logic          mem_valid_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // Scan from the farthest offset down so the nearest set bit above rr_ptr wins.
  always_comb begin
    winner = rr_ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (bus.i_req[rr_ptr_q + 2'(i)]) winner = rr_ptr_q + 2'(i);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|bus.i_req) state_d = ST_BUSY;
      ST_BUSY: if (bus.i_mem_ready || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_ptr_q    <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|bus.i_req) begin
            sel_q       <= winner;
            mem_valid_q <= 1'b1;
            mem_we_q    <= bus.i_we[winner];
            mem_addr_q  <= bus.i_addr[winner*AW +: AW];
            mem_wdata_q <= bus.i_wdata[winner*DW +: DW];
          end
        end
        ST_BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          // Ready takes priority over a coincident watchdog expiry.
          if (bus.i_mem_ready) begin
            mem_valid_q <= 1'b0;
            rdata_q     <= bus.i_mem_rdata;
            err_q       <= 1'b0;
          end else if (timeout_hit) begin
            mem_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b1;
          end
        end
        ST_RESP: begin
          rr_ptr_q <= sel_q + 2'd1;
          cnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_ack       = (state_q == ST_RESP) ? (4'b0001 << sel_q) : 4'b0000;
  assign bus.o_err       = (state_q == ST_RESP) && err_q;
  assign bus.o_rdata     = rdata_q;
  assign bus.o_sel       = sel_q;
  assign bus.o_mem_valid = mem_valid_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of the
// round-robin grant, watchdog outcome and ack timing.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  int   cyc     = 0;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  int            n_checks = 0;
  int            n_pass   = 0;
  int            rr_ptr   = 0;
  logic [DW-1:0] last_rdata = '0;
  int            last_ack_cyc = -1;
  int            ack_gap = 0;
  int            last_grant = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int i = 0; i < 4; i++)
      if (req[(ptr + i) % 4]) return (ptr + i) % 4;
    return 0;
  endfunction

  task automatic rand_fields();
    bus.i_addr  = {$urandom, $urandom, $urandom, $urandom};
    bus.i_wdata = {$urandom, $urandom, $urandom, $urandom};
    bus.i_we    = 4'($urandom);
  endtask

  task automatic model_reset();
    rr_ptr       = 0;
    last_rdata   = '0;
    last_ack_cyc = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},   bus.o_ack, 0);
    chk({tag, "_err"},   bus.o_err, 0);
    chk({tag, "_rdata"}, bus.o_rdata, 0);
    chk({tag, "_sel"},   bus.o_sel, 0);
    chk({tag, "_valid"}, bus.o_mem_valid, 0);
    chk({tag, "_we"},    bus.o_mem_we, 0);
    chk({tag, "_addr"},  bus.o_mem_addr, 0);
    chk({tag, "_wdata"}, bus.o_mem_wdata, 0);
  endtask

  // Entered at a negedge while the DUT idles; returns at the negedge of the next idle cycle.
  // dly = BUSY cycle (0-based) in which ready is raised; dly >= TO means never.
  task automatic run_txn(input logic [3:0] req, input int dly, input logic [DW-1:0] rd);
    int            w, nb;
    logic          e_we, e_err;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rd;
    chk("idle_ack",   bus.o_ack, 0);
    chk("idle_err",   bus.o_err, 0);
    chk("idle_valid", bus.o_mem_valid, 0);
    chk("rdata_hold", bus.o_rdata, last_rdata);
    bus.i_req       = req;
    bus.i_mem_ready = 1'b0;
    w       = pick(req, rr_ptr);
    e_we    = bus.i_we[w];
    e_addr  = bus.i_addr[w*AW +: AW];
    e_wdata = bus.i_wdata[w*DW +: DW];
    if (dly < TO) begin nb = dly + 1; e_err = 1'b0; e_rd = rd; end
    else          begin nb = TO;      e_err = 1'b1; e_rd = '0; end
    @(posedge i_clk); @(negedge i_clk);
    for (int b = 0; b < nb; b++) begin
      chk("busy_valid", bus.o_mem_valid, 1);
      chk("busy_sel",   bus.o_sel, w);
      chk("busy_we",    bus.o_mem_we, e_we);
      chk("busy_addr",  bus.o_mem_addr, e_addr);
      chk("busy_wdata", bus.o_mem_wdata, e_wdata);
      chk("busy_ack",   bus.o_ack, 0);
      chk("busy_err",   bus.o_err, 0);
      bus.i_mem_ready = (b == dly);
      bus.i_mem_rdata = (b == dly) ? rd : DW'($urandom);
      rand_fields();
      bus.i_req = 4'($urandom);
      @(posedge i_clk); @(negedge i_clk);
    end
    chk("resp_ack",   bus.o_ack, 4'b0001 << w);
    chk("resp_err",   bus.o_err, e_err);
    chk("resp_rdata", bus.o_rdata, e_rd);
    chk("resp_valid", bus.o_mem_valid, 0);
    chk("resp_sel",   bus.o_sel, w);
    ack_gap      = (last_ack_cyc >= 0) ? cyc - last_ack_cyc : 0;
    last_ack_cyc = cyc;
    last_grant   = w;
    rr_ptr       = (w + 1) % 4;
    last_rdata   = e_rd;
    bus.i_mem_ready = 1'b0;
    bus.i_req       = 4'b0000;
    @(posedge i_clk); @(negedge i_clk);
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    bus.i_req = '0; bus.i_we = '0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_mem_ready = 1'b0; bus.i_mem_rdata = '0;
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst_n = 1'b1;
    model_reset();

    // single read from load/store port
    rand_fields();
    bus.i_we[1] = 1'b0;
    bus.i_addr[1*AW +: AW] = 32'h100;
    run_txn(4'b0010, 0, 32'hDEADBEEF);

    // store from DMA with ready delayed 5 cycles
    rand_fields();
    bus.i_we[3] = 1'b1;
    bus.i_addr[3*AW +: AW]  = 32'h20;
    bus.i_wdata[3*DW +: DW] = 32'h55AA;
    run_txn(4'b1000, 5, DW'($urandom));

    // watchdog expiry, then a normal transaction, then ready on the last watchdog cycle
    rand_fields();
    run_txn(4'b0100, 100, DW'($urandom));
    rand_fields();
    run_txn(4'b0001, 2, DW'($urandom));
    rand_fields();
    run_txn(4'b0010, TO - 1, 32'hCAFEF00D);

    // reset in the middle of BUSY
    rand_fields();
    bus.i_req = 4'b0100;
    @(posedge i_clk); @(negedge i_clk);
    chk("pre_rst_valid", bus.o_mem_valid, 1);
    i_rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    @(negedge i_clk);
    chk("rst_held_ack", bus.o_ack, 0);
    bus.i_req = 4'b0000;
    i_rst_n = 1'b1;
    model_reset();
    @(negedge i_clk);
    rand_fields();
    run_txn(4'b1001, 0, DW'($urandom));
    chk("post_rst_grant", last_grant, 0);

    // fairness from a fresh pointer
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      rand_fields();
      run_txn(4'b1111, 0, DW'($urandom));
      chk("rr_order", last_grant, exp_order[k]);
      if (k > 0) chk("ack_gap", ack_gap, 3);
    end

    for (int k = 0; k < 40; k++) begin
      rand_fields();
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 10), DW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
